// File: rtl/ifmap_row_sched.sv
// ifmap_row_sched: IFMAP row scheduler with PPE broadcast and round-robin
// row service toward the router.
// Ports: clk, reset (async, active-high), start, ts_done, req/req_ack,
//   mem_rd_en/mem_ts/mem_row/mem_rd_data (row store), pkt_valid/pkt_ready/
//   pkt_data (router), busy, err (sticky).
module ifmap_row_sched #(
  parameter int NUM_PPE      = 5,
  parameter int IFMAP_SIZE   = 25,
  parameter int PPE_BASE_ID  = 5,
  parameter int OP_PPE_INPUT = 1,
  parameter int OP_NO_DATA   = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ts_done,
  input  logic [NUM_PPE-1:0]    req,
  output logic [NUM_PPE-1:0]    req_ack,
  output logic                  mem_rd_en,
  output logic                  mem_ts,
  output logic [4:0]            mem_row,
  input  logic [IFMAP_SIZE-1:0] mem_rd_data,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [32:0]           pkt_data,
  output logic                  busy,
  output logic                  err
);

  localparam int GW = $clog2(NUM_PPE);
  localparam logic [GW-1:0] LAST_PPE = GW'(NUM_PPE - 1);
  localparam logic [4:0] ROWS = 5'(IFMAP_SIZE);
  localparam logic [3:0] OPI = 4'(OP_PPE_INPUT);
  localparam logic [3:0] OPN = 4'(OP_NO_DATA);

  typedef enum logic [2:0] {
    IDLE, BC_RD, BC_WAIT, BC_SEND,
    SERVE, RD, WAIT, SEND
  } state_t;

  state_t state, nxt;

  logic          ts;
  logic          ts_pend;
  logic          ts_any;
  logic [GW-1:0] rr;
  logic [GW-1:0] g;
  logic [GW-1:0] bc;
  logic [GW-1:0] pick;
  logic          found;
  logic          oor;
  logic          in_range;
  logic [4:0]    ptr_g;
  logic [4:0]    ptr [NUM_PPE];
  logic [32:0]   pkt_q;

  function automatic logic [GW-1:0] wrap(
    input logic [GW-1:0] a,
    input int            i
  );
    int s;
    s = int'(a) + i;
    if (s >= NUM_PPE) s = s - NUM_PPE;
    return s[GW-1:0];
  endfunction

  function automatic logic [3:0] dest(
    input logic [GW-1:0] k
  );
    int s;
    s = PPE_BASE_ID + int'(k);
    return s[3:0];
  endfunction

  // A ts_done arriving in the same cycle as SERVE counts as pending.
  assign ts_any   = ts_pend | ts_done;
  assign ptr_g    = ptr[g];
  assign in_range = ptr_g < ROWS;

  // Round-robin: first set req bit at or after rr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_PPE; i++) begin
      if (!found && req[wrap(rr, i)]) begin
        found = 1'b1;
        pick  = wrap(rr, i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    req_ack   = '0;
    mem_rd_en = 1'b0;
    mem_row   = '0;
    pkt_valid = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = BC_RD;
      BC_RD: begin
        mem_rd_en = 1'b1;
        mem_row   = 5'(bc);
        nxt       = BC_WAIT;
      end
      BC_WAIT: nxt = BC_SEND;
      BC_SEND: begin
        pkt_valid = 1'b1;
        if (pkt_ready)
          nxt = (bc == LAST_PPE) ? SERVE : BC_RD;
      end
      SERVE: begin
        if (ts_any)     nxt = ts ? SERVE : BC_RD;
        else if (found) nxt = RD;
      end
      RD: begin
        req_ack[g] = 1'b1;
        if (in_range) begin
          mem_rd_en = 1'b1;
          mem_row   = ptr_g;
          nxt       = WAIT;
        end else begin
          nxt = SEND;
        end
      end
      WAIT: nxt = SEND;
      SEND: begin
        pkt_valid = 1'b1;
        if (pkt_ready) nxt = SERVE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign mem_ts   = mem_rd_en & ts;
  assign busy     = (state != IDLE) && (state != SERVE);
  assign pkt_data = pkt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts      <= 1'b0;
      ts_pend <= 1'b0;
      rr      <= '0;
      g       <= '0;
      bc      <= '0;
      oor     <= 1'b0;
      err     <= 1'b0;
      pkt_q   <= '0;
      for (int k = 0; k < NUM_PPE; k++)
        ptr[k] <= '0;
    end else begin
      if (state == SERVE && ts_any)
        ts_pend <= 1'b0;
      else if (ts_done && state != IDLE)
        ts_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            ts <= 1'b0;
            bc <= '0;
          end
        end
        BC_WAIT: pkt_q <= {dest(bc), OPI, mem_rd_data};
        BC_SEND: begin
          if (pkt_ready) begin
            ptr[bc] <= 5'(bc) + 5'd1;
            bc      <= bc + 1'b1;
          end
        end
        SERVE: begin
          if (ts_any) begin
            if (!ts) begin
              ts <= 1'b1;
              bc <= '0;
            end else begin
              err <= 1'b1;
            end
          end else if (found) begin
            g  <= pick;
            rr <= wrap(pick, 1);
          end
        end
        RD: begin
          oor <= !in_range;
          if (!in_range) begin
            err   <= 1'b1;
            pkt_q <= {dest(g), OPN, 25'd0};
          end
        end
        WAIT: pkt_q <= {dest(g), OPI, mem_rd_data};
        SEND: begin
          if (pkt_ready && !oor && in_range)
            ptr[g] <= ptr_g + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_row_sched.sv
// tb_ifmap_row_sched: directed bench for ifmap_row_sched.
// Memory row r of timestep t holds r*3 + t*1000.
module tb_ifmap_row_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ts_done;
  logic [4:0]  req;
  logic [4:0]  req_ack;
  logic        mem_rd_en;
  logic        mem_ts;
  logic [4:0]  mem_row;
  logic [24:0] mem_rd_data = '0;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [32:0] pkt_data;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  ifmap_row_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ts_done    (ts_done),
    .req        (req),
    .req_ack    (req_ack),
    .mem_rd_en  (mem_rd_en),
    .mem_ts     (mem_ts),
    .mem_row    (mem_row),
    .mem_rd_data(mem_rd_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en)
      mem_rd_data <= 25'(mem_row) * 25'd3
                   + (mem_ts ? 25'd1000 : 25'd0);

  function automatic logic [32:0] pk(
    input int d, input int op, input int data
  );
    logic [32:0] r;
    r = {d[3:0], op[3:0], data[24:0]};
    return r;
  endfunction

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic recv(
    input string tag,
    input logic [32:0] exp,
    input int hold
  );
    int n;
    n = 0;
    while (!pkt_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(pkt_valid), 64'd1);
    chk({tag, "_data"}, 64'(pkt_data), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {pkt_valid, pkt_data},
          {1'b1, exp});
    end
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
    chk({tag, "_drop"}, 64'(pkt_valid), 64'd0);
  endtask

  task automatic grant(
    input string tag,
    input int g,
    input int row,
    input int tsx
  );
    int n;
    n = 0;
    while (req_ack == 5'd0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ack"}, 64'(req_ack), 64'(1 << g));
    req[g] = 1'b0;
    if (row < 25) begin
      chk({tag, "_rd"}, {mem_rd_en, mem_ts, mem_row},
          {1'b1, tsx[0], row[4:0]});
    end else begin
      chk({tag, "_nord"}, 64'(mem_rd_en), 64'd0);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    start     = 1'b0;
    ts_done   = 1'b0;
    req       = '0;
    pkt_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic bcast(input string tag, input int off);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 5; b++)
      recv(tag, pk(5 + b, 1, b * 3 + off), 0);
  endtask

  initial begin
    int n;
    logic seen;

    // reset values
    reset     = 1'b1;
    start     = 1'b0;
    ts_done   = 1'b0;
    req       = '0;
    pkt_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 64'(req_ack), 64'd0);
    chk("rst_mem", {mem_rd_en, mem_ts, mem_row}, 64'd0);
    chk("rst_pkt", {pkt_valid, pkt_data}, 64'd0);
    chk("rst_flags", {busy, err}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_nord", 64'(mem_rd_en), 64'd0);

    // first broadcast, start latency
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_rd", {mem_rd_en, mem_ts, mem_row, busy},
        {1'b1, 1'b0, 5'd0, 1'b1});
    for (int b = 0; b < 5; b++)
      recv("bc", pk(5 + b, 1, b * 3), 0);
    chk("bc_serve", {busy, err}, 64'd0);

    // all requesters, round-robin order
    req = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      grant("rr", k, k + 1, 0);
      recv("rr", pk(5 + k, 1, (k + 1) * 3), 0);
    end

    // single requester with router backpressure
    @(negedge clk);
    req = 5'b00100;
    @(negedge clk);
    chk("c_ack", {req_ack, mem_rd_en, mem_row},
        {5'b00100, 1'b1, 5'd4});
    req = '0;
    @(negedge clk);
    chk("c_wait", 64'(pkt_valid), 64'd0);
    @(negedge clk);
    chk("c_n3", 64'(pkt_valid), 64'd1);
    recv("c", pk(7, 1, 12), 3);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pkt_valid || req_ack != 5'd0) seen = 1'b1;
    end
    chk("c_once", 64'(seen), 64'd0);

    // PPE 4 runs its pointer out
    do_reset();
    bcast("d_bc", 0);
    for (int k = 0; k < 20; k++) begin
      req = 5'b10000;
      grant("d", 4, 5 + k, 0);
      recv("d", pk(9, 1, (5 + k) * 3), 0);
    end
    chk("d_err0", 64'(err), 64'd0);
    req = 5'b10000;
    grant("d_oor", 4, 25, 0);
    @(negedge clk);
    chk("d_oor_n2", 64'(pkt_valid), 64'd1);
    recv("d_oor", pk(9, 14, 0), 0);
    chk("d_err1", 64'(err), 64'd1);

    // ts_done: ignored in IDLE, latched in SEND
    do_reset();
    ts_done = 1'b1;
    @(negedge clk);
    ts_done = 1'b0;
    @(negedge clk);
    bcast("e_bc", 0);
    req = 5'b00010;
    grant("e", 1, 2, 0);
    n = 0;
    while (!pkt_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    ts_done = 1'b1;
    @(negedge clk);
    ts_done = 1'b0;
    recv("e_send", pk(6, 1, 6), 1);
    n = 0;
    while (!mem_rd_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("e_rerun", {mem_rd_en, mem_ts, mem_row},
        {1'b1, 1'b1, 5'd0});
    for (int b = 0; b < 5; b++)
      recv("e_bc2", pk(5 + b, 1, b * 3 + 1000), 0);
    chk("e_err0", 64'(err), 64'd0);
    ts_done = 1'b1;
    @(negedge clk);
    ts_done = 1'b0;
    chk("e_err1", {err, busy}, {1'b1, 1'b0});
    req = 5'b01000;
    grant("e_ts1", 3, 4, 1);
    recv("e_ts1", pk(8, 1, 1012), 0);

    // reset during WAIT
    do_reset();
    bcast("f_bc", 0);
    req = 5'b00001;
    grant("f", 0, 1, 0);
    @(negedge clk);
    chk("f_wait", {busy, pkt_valid}, {1'b1, 1'b0});
    reset = 1'b1;
    #1;
    chk("f_rst_pkt", {pkt_valid, pkt_data}, 64'd0);
    chk("f_rst_out", {req_ack, mem_rd_en, busy, err},
        64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pkt_valid || mem_rd_en || busy) seen = 1'b1;
    end
    chk("f_idle", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
